// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions.
// Fetch state, reset PC default and word width.
package mips_pkg;
  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [WORD_W-1:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_st_e;
endpackage

// File: rtl/npc.sv
// Next-PC selection for the fetch stage.
// Priority jr > j > taken branch > sequential.
module npc
  import mips_pkg::*;
#(
  parameter bit HALT_ON_MA = 1'b1
) (
  input  logic [WORD_W-1:0] i_pc_f,
  input  logic [WORD_W-1:0] i_pc_d,
  input  logic              i_valid_d,
  input  logic              i_br_en,
  input  logic              i_cmp_out,
  input  logic [15:0]       i_br_imm16,
  input  logic              i_j_en,
  input  logic [25:0]       i_j_index26,
  input  logic              i_jr_en,
  input  logic [WORD_W-1:0] i_jr_target,
  output logic [WORD_W-1:0] o_next_pc,
  output logic              o_redirect,
  output logic              o_misaligned
);
  logic [WORD_W-1:0] w_pc_d4;
  logic [WORD_W-1:0] w_boff;
  logic [WORD_W-1:0] w_tgt;
  logic              w_take;

  assign w_pc_d4 = i_pc_d + 32'd4;
  assign w_boff  = {{14{i_br_imm16[15]}}, i_br_imm16, 2'b00};

  always_comb begin
    w_take = 1'b0;
    w_tgt  = i_pc_f + 32'd4;
    // A bubble in ID carries no control.
    if (i_valid_d) begin
      if (i_jr_en) begin
        w_take = 1'b1;
        w_tgt  = i_jr_target;
      end else if (i_j_en) begin
        w_take = 1'b1;
        w_tgt  = {w_pc_d4[31:28], i_j_index26, 2'b00};
      end else if (i_br_en && i_cmp_out) begin
        w_take = 1'b1;
        w_tgt  = w_pc_d4 + w_boff;
      end
    end
  end

  assign o_redirect   = w_take;
  assign o_misaligned = HALT_ON_MA && w_take && (w_tgt[1:0] != 2'b00);
  assign o_next_pc    = HALT_ON_MA ? w_tgt : {w_tgt[31:2], 2'b00};
endmodule

// File: rtl/fetch_unit.sv
// IF stage and IF/ID register with one-slot delayed redirect.
// Misaligned taken target halts fetch until reset.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter bit          HALT_ON_MA = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        br_en,
  input  logic        cmp_out,
  input  logic [15:0] br_imm16,
  input  logic        j_en,
  input  logic [25:0] j_index26,
  input  logic        jr_en,
  input  logic [31:0] jr_target,
  output logic [31:0] im_addr,
  input  logic [31:0] im_rdata,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc8_d,
  output logic        valid_d,
  output logic        fault
);
  fetch_st_e   r_st;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_pcd;
  logic        r_valid;
  logic        r_fault;

  logic [31:0] w_npc;
  logic        w_redir;
  logic        w_mis;

  npc #(
    .HALT_ON_MA(HALT_ON_MA)
  ) u_npc (
    .i_pc_f      (r_pc),
    .i_pc_d      (r_pcd),
    .i_valid_d   (r_valid),
    .i_br_en     (br_en),
    .i_cmp_out   (cmp_out),
    .i_br_imm16  (br_imm16),
    .i_j_en      (j_en),
    .i_j_index26 (j_index26),
    .i_jr_en     (jr_en),
    .i_jr_target (jr_target),
    .o_next_pc   (w_npc),
    .o_redirect  (w_redir),
    .o_misaligned(w_mis)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_st    <= BOOT;
      r_pc    <= RESET_PC;
      r_instr <= NOP_WORD;
      r_pcd   <= '0;
      r_valid <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      unique case (r_st)
        BOOT: r_st <= RUN;
        RUN: begin
          if (!stall) begin
            if (w_mis) begin
              r_fault <= 1'b1;
              r_st    <= HALT;
              r_valid <= 1'b0;
              r_instr <= NOP_WORD;
            end else begin
              // Delay slot at r_pc is latched whether or not we redirect.
              r_instr <= im_rdata;
              r_pcd   <= r_pc;
              r_valid <= 1'b1;
              r_pc    <= w_npc;
            end
          end
        end
        HALT: begin
          r_valid <= 1'b0;
          r_instr <= NOP_WORD;
        end
        default: r_st <= HALT;
      endcase
    end
  end

  assign im_addr = r_pc;
  assign instr_d = r_instr;
  assign pc_d    = r_pcd;
  assign pc8_d   = r_pcd + 32'd8;
  assign valid_d = r_valid;
  assign fault   = r_fault;

  logic w_unused;
  assign w_unused = w_redir;
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed cases then random control.
// Reference model tracks fetch PC, IF/ID contents and halt at word level.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        stall = 1'b0;
  logic        br_en = 1'b0;
  logic        cmp_out = 1'b0;
  logic [15:0] br_imm16 = '0;
  logic        j_en = 1'b0;
  logic [25:0] j_index26 = '0;
  logic        jr_en = 1'b0;
  logic [31:0] jr_target = '0;
  logic [31:0] im_addr, im_rdata, instr_d, pc_d, pc8_d;
  logic        valid_d, fault;

  fetch_unit dut (
    .clk(clk), .reset_n(reset_n), .stall(stall),
    .br_en(br_en), .cmp_out(cmp_out), .br_imm16(br_imm16),
    .j_en(j_en), .j_index26(j_index26),
    .jr_en(jr_en), .jr_target(jr_target),
    .im_addr(im_addr), .im_rdata(im_rdata),
    .instr_d(instr_d), .pc_d(pc_d), .pc8_d(pc8_d),
    .valid_d(valid_d), .fault(fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] imem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  assign im_rdata = imem(im_addr);

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] im;
    logic [31:0] instr;
    logic [31:0] pcd;
    logic        v;
    logic        f;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;

  // Architectural model: fetch PC, IF/ID contents, started/halted flags.
  logic [31:0] m_pc, m_pcd, m_instr;
  logic        m_v, m_f, m_up, m_halt;

  task automatic model_reset();
    m_pc = 32'h3000; m_pcd = 0; m_instr = 0;
    m_v = 0; m_f = 0; m_up = 0; m_halt = 0;
  endtask

  task automatic model_step();
    logic [31:0] tgt;
    logic        take;
    if (m_halt) return;
    if (!m_up) begin
      m_up = 1;
      return;
    end
    if (stall) return;
    take = 0;
    tgt = 0;
    if (m_v) begin
      if (jr_en) begin
        take = 1; tgt = jr_target;
      end else if (j_en) begin
        tgt = m_pcd + 4;
        take = 1; tgt = {tgt[31:28], j_index26, 2'b00};
      end else if (br_en && cmp_out) begin
        take = 1;
        tgt = m_pcd + 4 + 32'($signed(br_imm16)) * 4;
      end
    end
    if (take && tgt[1:0] != 2'b00) begin
      m_halt = 1; m_f = 1; m_v = 0; m_instr = 0;
      return;
    end
    m_instr = imem(m_pc);
    m_pcd = m_pc;
    m_v = 1;
    m_pc = take ? tgt : m_pc + 4;
  endtask

  task automatic tick();
    exp_t e;
    if (!reset_n) model_reset();
    else model_step();
    e.im = m_pc; e.instr = m_instr; e.pcd = m_pcd;
    e.v = m_v; e.f = m_f;
    sbq.push_back(e);
    @(posedge clk);
    #2;
  endtask

  always @(posedge clk) begin
    #1;
    if (sbq.size() > 0) begin
      mon_e = sbq.pop_front();
      chk("im_addr", im_addr, mon_e.im);
      chk("instr_d", instr_d, mon_e.instr);
      chk("pc_d", pc_d, mon_e.pcd);
      chk("pc8_d", pc8_d, mon_e.pcd + 32'd8);
      chk("valid_d", {31'd0, valid_d}, {31'd0, mon_e.v});
      chk("fault", {31'd0, fault}, {31'd0, mon_e.f});
    end
  end

  task automatic clr();
    stall = 0; br_en = 0; cmp_out = 0; br_imm16 = 0;
    j_en = 0; j_index26 = 0; jr_en = 0; jr_target = 0;
  endtask

  logic [31:0] rnd;

  initial begin
    model_reset();
    tick(); tick();
    reset_n = 1;
    tick();
    chk("boot_addr", im_addr, 32'h3000);
    chk("boot_valid", {31'd0, valid_d}, 32'd0);
    tick();
    chk("first_instr", instr_d, imem(32'h3000));
    chk("first_pc8", pc8_d, 32'h3008);
    chk("seq_1", im_addr, 32'h3004);
    tick(); chk("seq_2", im_addr, 32'h3008);
    tick(); chk("seq_3", im_addr, 32'h300C);
    br_en = 1; cmp_out = 1; br_imm16 = 16'hFFFE;
    tick();
    chk("beq_taken", im_addr, 32'h3004);
    chk("beq_dslot", pc_d, 32'h300C);
    clr(); tick(); tick();
    br_en = 1; cmp_out = 0; br_imm16 = 16'hFFFE;
    tick();
    chk("beq_not", im_addr, 32'h3010);
    clr();

    reset_n = 0;
    #1;
    chk("rst_async_addr", im_addr, 32'h3000);
    tick();
    reset_n = 1;
    tick(); tick();
    j_en = 1; j_index26 = 26'h0000C10;
    tick();
    chk("j_target", im_addr, 32'h3040);
    chk("j_dslot", pc_d, 32'h3004);
    jr_en = 1; jr_target = 32'h3100;
    tick();
    chk("jr_wins", im_addr, 32'h3100);
    clr();

    stall = 1; br_en = 1; cmp_out = 1; br_imm16 = 16'h0010;
    tick(); tick();
    chk("stall_addr", im_addr, 32'h3100);
    chk("stall_pcd", pc_d, 32'h3040);
    stall = 0;
    tick();
    chk("post_stall_br", im_addr, 32'h3084);
    clr();

    jr_en = 1; jr_target = 32'h3102;
    tick();
    chk("ma_fault", {31'd0, fault}, 32'd1);
    clr();
    tick(); tick(); tick();
    chk("halt_frozen", im_addr, 32'h3084);
    chk("halt_valid", {31'd0, valid_d}, 32'd0);
    reset_n = 0;
    #1;
    chk("rst_fault", {31'd0, fault}, 32'd0);
    chk("rst_addr", im_addr, 32'h3000);
    tick();
    reset_n = 1;

    for (int i = 0; i < 600; i++) begin
      if (!reset_n) reset_n = 1;
      else if ($urandom_range(99) == 0) reset_n = 0;
      else if (m_halt && $urandom_range(7) == 0) reset_n = 0;
      stall = ($urandom_range(4) == 0);
      br_en = ($urandom_range(2) == 0);
      cmp_out = 1'($urandom);
      br_imm16 = 16'($urandom);
      j_en = ($urandom_range(7) == 0);
      j_index26 = 26'($urandom);
      jr_en = ($urandom_range(7) == 0);
      rnd = $urandom;
      jr_target = (rnd & ~32'h3) |
                  (($urandom_range(29) == 0) ? 32'h2 : 32'h0);
      tick();
    end
    clr();
    reset_n = 1;
    tick(); tick();
    #1;
    chk("sb_drain", sbq.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
